// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operation sequencer: ALU/MDU control codes,
// ALUOp classes, sequencer FSM states and the R-type funct lookup table.
package alu_pkg;

    localparam int ALU_CTRL_W = 4;
    localparam int FUNCT_W    = 10;
    localparam int CNT_W      = 7;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_AND  = 4'b0000,
        ALU_XOR  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_ADD  = 4'b0011,
        ALU_SUB  = 4'b0100,
        ALU_MUL  = 4'b0101,
        ALU_ADDI = 4'b0110,
        ALU_SRAI = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_SRL  = 4'b1001,
        ALU_SRA  = 4'b1010,
        ALU_SLT  = 4'b1011,
        ALU_MULH = 4'b1100,
        ALU_DIV  = 4'b1101,
        ALU_REM  = 4'b1110,
        ALU_NOP  = 4'b1111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_RSVD   = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // R-type {funct7, funct3} table; both tables share the same entry order.
    localparam int R_TBL_N = 13;

    localparam logic [R_TBL_N-1:0][FUNCT_W-1:0] R_FUNCT_TBL = {
        10'b0000000_111, 10'b0000000_100, 10'b0000000_001, 10'b0000000_000,
        10'b0100000_000, 10'b0000001_000, 10'b0000000_110, 10'b0000000_101,
        10'b0100000_101, 10'b0000000_010, 10'b0000001_001, 10'b0000001_100,
        10'b0000001_110
    };

    localparam logic [R_TBL_N-1:0][ALU_CTRL_W-1:0] R_CODE_TBL = {
        ALU_AND,  ALU_XOR,  ALU_SLL,  ALU_ADD,
        ALU_SUB,  ALU_MUL,  ALU_OR,   ALU_SRL,
        ALU_SRA,  ALU_SLT,  ALU_MULH, ALU_DIV,
        ALU_REM
    };

endpackage

// File: rtl/alu_op_sequencer_if.sv
// EX-stage instruction/control bundle between the pipeline and the sequencer.
interface alu_op_sequencer_if;
    import alu_pkg::*;

    logic                  valid_i;
    logic [FUNCT_W-1:0]    funct_i;
    logic [1:0]            ALUOp_i;
    logic                  flush_i;
    logic [ALU_CTRL_W-1:0] ALUCtrl_o;
    logic                  stall_o;
    logic                  mdu_start_o;
    logic                  mdu_done_o;
    logic                  illegal_o;

    modport master (
        output valid_i, funct_i, ALUOp_i, flush_i,
        input  ALUCtrl_o, stall_o, mdu_start_o, mdu_done_o, illegal_o
    );

    modport slave (
        input  valid_i, funct_i, ALUOp_i, flush_i,
        output ALUCtrl_o, stall_o, mdu_start_o, mdu_done_o, illegal_o
    );
endinterface

// File: rtl/alu_decode.sv
// Purely combinational funct/ALUOp decode into an ALU/MDU control code,
// plus multi-cycle and divider classification.
module alu_decode
    import alu_pkg::*;
(
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [1:0]         ALUOp_i,
    output alu_ctrl_e          code,
    output logic               is_multi,
    output logic               is_div,
    output logic               illegal
);

    logic [R_TBL_N-1:0]    r_hit;
    logic [ALU_CTRL_W-1:0] r_code;

    genvar gi;
    generate
        for (gi = 0; gi < R_TBL_N; gi++) begin : g_rmatch
            assign r_hit[gi] = (funct_i == R_FUNCT_TBL[gi]);
        end
    endgenerate

    // Table entries are unique, so at most one hit contributes to the OR.
    always_comb begin
        r_code = '0;
        for (int i = 0; i < R_TBL_N; i++) begin
            if (r_hit[i]) begin
                r_code = r_code | R_CODE_TBL[i];
            end
        end
    end

    always_comb begin
        code    = ALU_NOP;
        illegal = 1'b1;
        case (ALUOp_i)
            ALUOP_MEM: begin
                case (funct_i[2:0])
                    3'b000:  begin code = ALU_ADDI; illegal = 1'b0; end
                    3'b101:  begin code = ALU_SRAI; illegal = 1'b0; end
                    3'b010:  begin code = ALU_ADD;  illegal = 1'b0; end
                    default: begin code = ALU_NOP;  illegal = 1'b1; end
                endcase
            end
            ALUOP_BRANCH: begin
                code    = ALU_SUB;
                illegal = 1'b0;
            end
            ALUOP_RTYPE: begin
                if (|r_hit) begin
                    code    = alu_ctrl_e'(r_code);
                    illegal = 1'b0;
                end
            end
            default: begin
                code    = ALU_NOP;
                illegal = 1'b1;
            end
        endcase
    end

    assign is_multi = code inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
    assign is_div   = code inside {ALU_DIV, ALU_REM};

endmodule

// File: rtl/alu_op_sequencer.sv
// EX-stage ALU control with a multi-cycle MDU sequencer: launches MUL/DIV
// class ops, stalls the front of the pipe for a fixed latency, pulses done.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 33
) (
    input  logic               clk_i,
    input  logic               rst_i,
    alu_op_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    alu_ctrl_e  dec_code;
    logic       dec_is_multi;
    logic       dec_is_div;
    logic       dec_illegal;

    seq_state_e       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    alu_ctrl_e        code_reg;

    logic             in_idle;
    logic             accept;
    logic             pass_decode;
    logic [CNT_W-1:0] lat_load;

    alu_decode u_decode (
        .funct_i  (bus.funct_i),
        .ALUOp_i  (bus.ALUOp_i),
        .code     (dec_code),
        .is_multi (dec_is_multi),
        .is_div   (dec_is_div),
        .illegal  (dec_illegal)
    );

    assign in_idle  = (state_reg == ST_IDLE);
    assign accept   = in_idle && bus.valid_i && !bus.flush_i && dec_is_multi;
    assign lat_load = dec_is_div ? DIV_LOAD : MUL_LOAD;

    // cnt holds remaining BUSY cycles; the cycle seeing cnt==1 is the last stall.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            code_reg  <= ALU_NOP;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg <= ST_BUSY;
                        cnt_reg   <= lat_load;
                        code_reg  <= dec_code;
                    end
                end
                ST_BUSY: begin
                    if (bus.flush_i) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                        if (cnt_reg == CNT_W'(1)) begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // While reset is held the decode stays visible but all handshakes are quiet.
    assign pass_decode     = in_idle || !rst_i;
    assign bus.ALUCtrl_o   = pass_decode ? dec_code : code_reg;
    assign bus.illegal_o   = pass_decode && bus.valid_i && dec_illegal;
    assign bus.mdu_start_o = rst_i && accept;
    assign bus.stall_o     = rst_i && (accept || ((state_reg == ST_BUSY) && !bus.flush_i));
    assign bus.mdu_done_o  = rst_i && (state_reg == ST_DONE) && !bus.flush_i;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: decode table, MDU latency, flush,
// mid-op reset and back-to-back launches, all against hand-computed values.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 33;

    localparam logic [9:0] F_ADD  = 10'b0000000_000;
    localparam logic [9:0] F_MUL  = 10'b0000001_000;
    localparam logic [9:0] F_MULH = 10'b0000001_001;
    localparam logic [9:0] F_DIV  = 10'b0000001_100;
    localparam logic [9:0] F_REM  = 10'b0000001_110;

    typedef struct packed {
        logic [1:0] op;
        logic [9:0] funct;
        logic       valid;
        logic       flush;
        logic [3:0] code;
        logic       ill;
    } dec_vec_t;

    localparam int NDEC = 23;
    localparam dec_vec_t DEC_VECS [NDEC] = '{
        '{2'b10, 10'b0000000111, 1'b1, 1'b0, 4'b0000, 1'b0},
        '{2'b10, 10'b0000000100, 1'b1, 1'b0, 4'b0001, 1'b0},
        '{2'b10, 10'b0000000001, 1'b1, 1'b0, 4'b0010, 1'b0},
        '{2'b10, 10'b0000000000, 1'b1, 1'b0, 4'b0011, 1'b0},
        '{2'b10, 10'b0100000000, 1'b1, 1'b0, 4'b0100, 1'b0},
        '{2'b10, 10'b0000000110, 1'b1, 1'b0, 4'b1000, 1'b0},
        '{2'b10, 10'b0000000101, 1'b1, 1'b0, 4'b1001, 1'b0},
        '{2'b10, 10'b0100000101, 1'b1, 1'b0, 4'b1010, 1'b0},
        '{2'b10, 10'b0000000010, 1'b1, 1'b0, 4'b1011, 1'b0},
        '{2'b10, 10'b0000001000, 1'b1, 1'b1, 4'b0101, 1'b0},
        '{2'b10, 10'b0000001001, 1'b1, 1'b1, 4'b1100, 1'b0},
        '{2'b10, 10'b0000001100, 1'b1, 1'b1, 4'b1101, 1'b0},
        '{2'b10, 10'b0000001110, 1'b1, 1'b1, 4'b1110, 1'b0},
        '{2'b10, 10'b1111111000, 1'b1, 1'b0, 4'b1111, 1'b1},
        '{2'b10, 10'b0000001010, 1'b1, 1'b0, 4'b1111, 1'b1},
        '{2'b00, 10'b1010101000, 1'b1, 1'b0, 4'b0110, 1'b0},
        '{2'b00, 10'b0100000101, 1'b1, 1'b0, 4'b0111, 1'b0},
        '{2'b00, 10'b0000000010, 1'b1, 1'b0, 4'b0011, 1'b0},
        '{2'b00, 10'b0000000001, 1'b1, 1'b0, 4'b1111, 1'b1},
        '{2'b01, 10'b1111111111, 1'b1, 1'b0, 4'b0100, 1'b0},
        '{2'b11, 10'b0000000000, 1'b1, 1'b0, 4'b1111, 1'b1},
        '{2'b11, 10'b0000000000, 1'b0, 1'b0, 4'b1111, 1'b0},
        '{2'b10, 10'b0000001000, 1'b0, 1'b0, 4'b0101, 1'b0}
    };

    logic clk_i = 1'b0;
    logic rst_i;
    int   checks = 0;
    int   passed = 0;

    alu_op_sequencer_if bus();

    alu_op_sequencer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change 1 time unit after the rising edge; outputs sampled 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [9:0] f, input logic [1:0] op, input logic fl);
        bus.valid_i = v;
        bus.funct_i = f;
        bus.ALUOp_i = op;
        bus.flush_i = fl;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        drive(1'b1, F_MUL, 2'b10, 1'b0);
        #1;
        checks++; if (bus.stall_o !== 1'b0) $display("FAIL rst_stall got %b want 0", bus.stall_o); else passed++;
        checks++; if (bus.mdu_start_o !== 1'b0) $display("FAIL rst_start got %b want 0", bus.mdu_start_o); else passed++;
        checks++; if (bus.mdu_done_o !== 1'b0) $display("FAIL rst_done got %b want 0", bus.mdu_done_o); else passed++;
        checks++; if (bus.ALUCtrl_o !== 4'b0101) $display("FAIL rst_code got %b want 0101", bus.ALUCtrl_o); else passed++;
        tick();
        drive(1'b1, F_ADD, 2'b11, 1'b0);
        #1;
        checks++; if (bus.ALUCtrl_o !== 4'b1111) $display("FAIL rst_code_rsvd got %b want 1111", bus.ALUCtrl_o); else passed++;
        checks++; if (bus.illegal_o !== 1'b1) $display("FAIL rst_illegal got %b want 1", bus.illegal_o); else passed++;
        tick();
        rst_i = 1'b1;
        drive(1'b0, F_ADD, 2'b10, 1'b0);
        tick();
        $display("reset: released");
    endtask

    task automatic test_decode();
        dec_vec_t v;
        for (int i = 0; i < NDEC; i++) begin
            v = DEC_VECS[i];
            drive(v.valid, v.funct, v.op, v.flush);
            #1;
            $display("decode[%0d] op=%b funct=%b valid=%b flush=%b -> code=%b illegal=%b",
                     i, v.op, v.funct, v.valid, v.flush, bus.ALUCtrl_o, bus.illegal_o);
            checks++; if (bus.ALUCtrl_o !== v.code) $display("FAIL dec_code[%0d] got %b want %b", i, bus.ALUCtrl_o, v.code); else passed++;
            checks++; if (bus.illegal_o !== v.ill) $display("FAIL dec_illegal[%0d] got %b want %b", i, bus.illegal_o, v.ill); else passed++;
            checks++; if (bus.stall_o !== 1'b0) $display("FAIL dec_stall[%0d] got %b want 0", i, bus.stall_o); else passed++;
            checks++; if (bus.mdu_start_o !== 1'b0) $display("FAIL dec_start[%0d] got %b want 0", i, bus.mdu_start_o); else passed++;
            tick();
        end
        drive(1'b0, F_ADD, 2'b10, 1'b0);
    endtask

    // Full run: accept at k=0, done at k=lat, pipeline offers ADD meanwhile.
    task automatic test_mdu_run(input logic [9:0] f, input logic [3:0] code, input int lat, input string name);
        logic       e_stall, e_start, e_done;
        logic [3:0] e_code;
        for (int k = 0; k <= lat + 1; k++) begin
            if (k == 0) drive(1'b1, f, 2'b10, 1'b0);
            else        drive(1'b1, F_ADD, 2'b10, 1'b0);
            #1;
            e_stall = (k < lat);
            e_start = (k == 0);
            e_done  = (k == lat);
            e_code  = (k <= lat) ? code : 4'b0011;
            checks++; if (bus.stall_o !== e_stall) $display("FAIL %s_stall k=%0d got %b want %b", name, k, bus.stall_o, e_stall); else passed++;
            checks++; if (bus.mdu_start_o !== e_start) $display("FAIL %s_start k=%0d got %b want %b", name, k, bus.mdu_start_o, e_start); else passed++;
            checks++; if (bus.mdu_done_o !== e_done) $display("FAIL %s_done k=%0d got %b want %b", name, k, bus.mdu_done_o, e_done); else passed++;
            checks++; if (bus.ALUCtrl_o !== e_code) $display("FAIL %s_code k=%0d got %b want %b", name, k, bus.ALUCtrl_o, e_code); else passed++;
            tick();
        end
        drive(1'b0, F_ADD, 2'b10, 1'b0);
        tick();
        $display("%s: run of latency %0d complete", name, lat);
    endtask

    task automatic test_div_flush();
        logic       e_stall;
        logic [3:0] e_code;
        for (int k = 0; k <= 40; k++) begin
            if (k == 0)      drive(1'b1, F_DIV, 2'b10, 1'b0);
            else if (k < 5)  drive(1'b0, F_ADD, 2'b10, 1'b0);
            else if (k == 5) drive(1'b0, F_ADD, 2'b10, 1'b1);
            else             drive(1'b1, F_ADD, 2'b10, 1'b0);
            #1;
            e_stall = (k <= 4);
            e_code  = (k <= 5) ? 4'b1101 : 4'b0011;
            checks++; if (bus.stall_o !== e_stall) $display("FAIL dflush_stall k=%0d got %b want %b", k, bus.stall_o, e_stall); else passed++;
            checks++; if (bus.mdu_done_o !== 1'b0) $display("FAIL dflush_done k=%0d got %b want 0", k, bus.mdu_done_o); else passed++;
            if (k <= 7) begin
                checks++; if (bus.ALUCtrl_o !== e_code) $display("FAIL dflush_code k=%0d got %b want %b", k, bus.ALUCtrl_o, e_code); else passed++;
            end
            tick();
        end
        drive(1'b0, F_ADD, 2'b10, 1'b0);
        tick();
        $display("div_flush: DIV flushed at accept+5");
    endtask

    task automatic test_flush_done();
        for (int k = 0; k <= 5; k++) begin
            if (k == 0)      drive(1'b1, F_MUL, 2'b10, 1'b0);
            else if (k == 4) drive(1'b0, F_ADD, 2'b10, 1'b1);
            else             drive(1'b0, F_ADD, 2'b10, 1'b0);
            #1;
            checks++; if (bus.mdu_done_o !== 1'b0) $display("FAIL fdone_done k=%0d got %b want 0", k, bus.mdu_done_o); else passed++;
            checks++; if (bus.stall_o !== (k <= 3)) $display("FAIL fdone_stall k=%0d got %b want %b", k, bus.stall_o, (k <= 3)); else passed++;
            tick();
        end
        $display("flush_done: MUL flushed in its done cycle");
    endtask

    task automatic test_reset_mid();
        logic e_stall, e_start, e_done;
        for (int k = 0; k <= 12; k++) begin
            rst_i = (k == 2) ? 1'b0 : 1'b1;
            if (k == 0 || k == 7) drive(1'b1, F_MUL, 2'b10, 1'b0);
            else                  drive(1'b0, F_ADD, 2'b10, 1'b0);
            #1;
            e_stall = (k <= 1) || (k >= 7 && k <= 10);
            e_start = (k == 0) || (k == 7);
            e_done  = (k == 11);
            checks++; if (bus.stall_o !== e_stall) $display("FAIL rmid_stall k=%0d got %b want %b", k, bus.stall_o, e_stall); else passed++;
            checks++; if (bus.mdu_start_o !== e_start) $display("FAIL rmid_start k=%0d got %b want %b", k, bus.mdu_start_o, e_start); else passed++;
            checks++; if (bus.mdu_done_o !== e_done) $display("FAIL rmid_done k=%0d got %b want %b", k, bus.mdu_done_o, e_done); else passed++;
            if (k == 8) begin
                checks++; if (bus.ALUCtrl_o !== 4'b0101) $display("FAIL rmid_code got %b want 0101", bus.ALUCtrl_o); else passed++;
            end
            tick();
        end
        rst_i = 1'b1;
        $display("reset_mid: MUL discarded, next MUL completed");
    endtask

    task automatic test_back_to_back();
        logic e_stall, e_start, e_done;
        int   dones = 0;
        for (int k = 0; k <= 11; k++) begin
            if (k <= 5) drive(1'b1, F_MUL, 2'b10, 1'b0);
            else        drive(1'b0, F_ADD, 2'b10, 1'b0);
            #1;
            e_stall = (k <= 3) || (k >= 5 && k <= 8);
            e_start = (k == 0) || (k == 5);
            e_done  = (k == 4) || (k == 9);
            if (bus.mdu_done_o === 1'b1) dones++;
            checks++; if (bus.stall_o !== e_stall) $display("FAIL b2b_stall k=%0d got %b want %b", k, bus.stall_o, e_stall); else passed++;
            checks++; if (bus.mdu_start_o !== e_start) $display("FAIL b2b_start k=%0d got %b want %b", k, bus.mdu_start_o, e_start); else passed++;
            checks++; if (bus.mdu_done_o !== e_done) $display("FAIL b2b_done k=%0d got %b want %b", k, bus.mdu_done_o, e_done); else passed++;
            tick();
        end
        checks++; if (dones !== 2) $display("FAIL b2b_done_count got %0d want 2", dones); else passed++;
        $display("back_to_back: %0d done pulses", dones);
    endtask

    initial begin
        drive(1'b0, F_ADD, 2'b10, 1'b0);
        test_reset();
        test_decode();
        test_mdu_run(F_MUL,  4'b0101, MUL_LAT, "mul");
        test_mdu_run(F_MULH, 4'b1100, MUL_LAT, "mulh");
        test_mdu_run(F_REM,  4'b1110, DIV_LAT, "rem");
        test_div_flush();
        test_flush_done();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
